// File: rtl/aes_decrypt_sequencer.sv
// aes_decrypt_sequencer
// Control FSM for the AES-128 decryption datapath. It sequences key expansion,
// ciphertext load, the initial AddRoundKey, NUM_ROUNDS-1 full inverse rounds
// (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns one column per cycle)
// and a final round without InvMixColumns. It then writes the result and
// reports Done.
// Optional feature macro: AES_SEQ_ABORT_EN. When defined, dropping AES_START
// while busy aborts the run. No result is written and Done is not raised.
module aes_decrypt_sequencer #(
  parameter int NUM_ROUNDS    = 10,  // 2..15
  parameter int KEYEXP_CYCLES = 12   // 1..255
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       AES_START,
  output logic       KEYEXP_GO,
  output logic       LOAD_STATE,
  output logic [2:0] OP_SEL,
  output logic [3:0] ROUND_IDX,
  output logic [1:0] MIX_COL,
  output logic       STATE_WE,
  output logic       RESULT_WE,
  output logic       BUSY,
  output logic       AES_DONE
);

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_ADD_KEY   = 3'd1;
  localparam logic [2:0] OP_INV_SHIFT = 3'd2;
  localparam logic [2:0] OP_INV_SUB   = 3'd3;
  localparam logic [2:0] OP_INV_MIX   = 3'd4;

  localparam logic [7:0] KEYEXP_LAST = 8'(KEYEXP_CYCLES - 1);
  localparam logic [3:0] ROUND_TOP   = 4'(NUM_ROUNDS);
  localparam logic [3:0] ROUND_FIRST = 4'(NUM_ROUNDS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_KEYEXP,
    S_LOAD,
    S_ARK0,
    S_ISR,
    S_ISB,
    S_ARK,
    S_IMC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] kcnt_q, kcnt_d;    // key-expansion wait counter
  logic [3:0] r_q, r_d;          // round counter
  logic [1:0] c_q, c_d;          // InvMixColumns column counter
  logic       keygo_q, keygo_d;  // registered so the pulse has no path from AES_START

  // Next-state and counter updates.
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    r_d     = r_q;
    c_d     = c_q;
    keygo_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Only reachable after AES_START was sampled low, so any high level
        // seen here is a fresh start request.
        if (AES_START) begin
          state_d = S_KEYEXP;
          kcnt_d  = 8'd0;
          keygo_d = 1'b1;
        end
      end
      S_KEYEXP: begin
        if (kcnt_q == KEYEXP_LAST) begin
          state_d = S_LOAD;
        end else begin
          kcnt_d = kcnt_q + 8'd1;
        end
      end
      S_LOAD: state_d = S_ARK0;
      S_ARK0: begin
        r_d     = ROUND_FIRST;
        state_d = S_ISR;
      end
      S_ISR: state_d = S_ISB;
      S_ISB: state_d = S_ARK;
      S_ARK: begin
        // Round 0 is the final round and skips InvMixColumns.
        if (r_q == 4'd0) begin
          state_d = S_WRITE;
        end else begin
          c_d     = 2'd0;
          state_d = S_IMC;
        end
      end
      S_IMC: begin
        if (c_q == 2'd3) begin
          r_d     = r_q - 4'd1;
          state_d = S_ISR;
        end else begin
          c_d = c_q + 2'd1;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE: begin
        if (!AES_START) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef AES_SEQ_ABORT_EN
    // Abort: a low start level in any busy state returns to IDLE without
    // passing through WRITE, so the result registers are never touched.
    if (state_q != S_IDLE && state_q != S_DONE && !AES_START) begin
      state_d = S_IDLE;
      keygo_d = 1'b0;
    end
`endif
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      kcnt_q  <= 8'd0;
      r_q     <= 4'd0;
      c_q     <= 2'd0;
      keygo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      r_q     <= r_d;
      c_q     <= c_d;
      keygo_q <= keygo_d;
    end
  end

  // Output decode from state and counters only.
  always_comb begin
    KEYEXP_GO  = 1'b0;
    LOAD_STATE = 1'b0;
    OP_SEL     = OP_NOP;
    ROUND_IDX  = 4'd0;
    MIX_COL    = 2'd0;
    STATE_WE   = 1'b0;
    RESULT_WE  = 1'b0;
    BUSY       = 1'b1;
    AES_DONE   = 1'b0;
    case (state_q)
      S_IDLE:   BUSY = 1'b0;
      S_KEYEXP: KEYEXP_GO = keygo_q;
      S_LOAD: begin
        LOAD_STATE = 1'b1;
        STATE_WE   = 1'b1;
      end
      S_ARK0: begin
        OP_SEL    = OP_ADD_KEY;
        ROUND_IDX = ROUND_TOP;
        STATE_WE  = 1'b1;
      end
      S_ISR: begin
        OP_SEL   = OP_INV_SHIFT;
        STATE_WE = 1'b1;
      end
      S_ISB: begin
        OP_SEL   = OP_INV_SUB;
        STATE_WE = 1'b1;
      end
      S_ARK: begin
        OP_SEL    = OP_ADD_KEY;
        ROUND_IDX = r_q;
        STATE_WE  = 1'b1;
      end
      S_IMC: begin
        OP_SEL   = OP_INV_MIX;
        MIX_COL  = c_q;
        STATE_WE = 1'b1;
      end
      S_WRITE:  RESULT_WE = 1'b1;
      S_DONE: begin
        BUSY     = 1'b0;
        AES_DONE = 1'b1;
      end
      default:  BUSY = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Testbench for aes_decrypt_sequencer: an expected per-cycle output trace is
// queued when a run is started and popped/compared as the DUT steps through it.
module tb_aes_decrypt_sequencer;

  localparam int K   = 12;
  localparam int NR  = 10;
  localparam int LAT = K + 6 + 7 * (NR - 1);          // first KEYEXP to first DONE
  localparam int IDX_RESET = K + 2 + 7 * (NR - 1 - 5) + 4;  // IMC col 1, round 5
  localparam int IDX_ABORT = K + 2 + 7 * (NR - 1 - 3) + 1;  // ISB, round 3

  logic       CLK;
  logic       RESET_N;
  logic       AES_START;
  logic       KEYEXP_GO;
  logic       LOAD_STATE;
  logic [2:0] OP_SEL;
  logic [3:0] ROUND_IDX;
  logic [1:0] MIX_COL;
  logic       STATE_WE;
  logic       RESULT_WE;
  logic       BUSY;
  logic       AES_DONE;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  aes_decrypt_sequencer #(.NUM_ROUNDS(NR), .KEYEXP_CYCLES(K)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .AES_START(AES_START),
    .KEYEXP_GO(KEYEXP_GO), .LOAD_STATE(LOAD_STATE), .OP_SEL(OP_SEL),
    .ROUND_IDX(ROUND_IDX), .MIX_COL(MIX_COL), .STATE_WE(STATE_WE),
    .RESULT_WE(RESULT_WE), .BUSY(BUSY), .AES_DONE(AES_DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // {keygo, load, op[2:0], ridx[3:0], mix[1:0], state_we, result_we, busy, done}
  function automatic logic [14:0] vec(input logic kg, input logic ld,
                                      input logic [2:0] op, input logic [3:0] ri,
                                      input logic [1:0] mc, input logic swe,
                                      input logic rwe, input logic bsy,
                                      input logic dn);
    return {kg, ld, op, ri, mc, swe, rwe, bsy, dn};
  endfunction

  function automatic logic [14:0] obs();
    return {KEYEXP_GO, LOAD_STATE, OP_SEL, ROUND_IDX, MIX_COL,
            STATE_WE, RESULT_WE, BUSY, AES_DONE};
  endfunction

  // Expected trace of one complete run, first KEYEXP cycle through first DONE cycle.
  task automatic push_run_trace();
    exp_q.delete();
    for (int i = 0; i < K; i++)
      exp_q.push_back(vec(i == 0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(vec(1'b0, 1'b1, 3'd0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(vec(1'b0, 1'b0, 3'd1, 4'(NR), 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    for (int r = NR - 1; r >= 0; r--) begin
      exp_q.push_back(vec(1'b0, 1'b0, 3'd2, 4'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(vec(1'b0, 1'b0, 3'd3, 4'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(vec(1'b0, 1'b0, 3'd1, 4'(r), 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
      if (r > 0)
        for (int c = 0; c < 4; c++)
          exp_q.push_back(vec(1'b0, 1'b0, 3'd4, 4'd0, 2'(c), 1'b1, 1'b0, 1'b1, 1'b0));
    end
    exp_q.push_back(vec(1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(vec(1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic test_reset();
    logic [14:0] got;
    RESET_N   = 1'b0;
    AES_START = 1'b0;
    repeat (2) @(negedge CLK);
    got = obs();
    checks++;
    if (got !== 15'd0) begin
      errors++;
      $display("FAIL reset_outs got %h exp %h", got, 15'd0);
    end
    RESET_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      got = obs();
      checks++;
      if (got !== 15'd0) begin
        errors++;
        $display("FAIL idle_outs cyc %0d got %h exp %h", i, got, 15'd0);
      end
    end
    $display("reset: 2 cycles reset, 20 cycles idle checked");
  endtask

  task automatic test_full_run(input string tag);
    logic [14:0] got, exp;
    int n, first_done;
    push_run_trace();
    n = exp_q.size();
    first_done = -1;
    AES_START = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      got = obs();
      exp = exp_q.pop_front();
      if (AES_DONE === 1'b1 && first_done < 0) first_done = i;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_trace cyc %0d got %h exp %h", tag, i, got, exp);
      end
    end
    checks++;
    if (first_done != LAT) begin
      errors++;
      $display("FAIL %s_latency got %0d exp %0d", tag, first_done, LAT);
    end
    // Start held: Done must persist.
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if (AES_DONE !== 1'b1 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL %s_done_hold cyc %0d got done=%b busy=%b exp done=1 busy=0",
                 tag, i, AES_DONE, BUSY);
      end
    end
    AES_START = 1'b0;
    @(negedge CLK);
    got = obs();
    checks++;
    if (got !== 15'd0) begin
      errors++;
      $display("FAIL %s_done_exit got %h exp %h", tag, got, 15'd0);
    end
    $display("run %s: done after %0d cycles, released to idle", tag, first_done);
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    test_full_run("second");
  endtask

  task automatic test_short_pulse();
    logic [14:0] got, exp;
    int n;
    push_run_trace();
    n = exp_q.size();
    AES_START = 1'b1;
    @(negedge CLK);
    got = obs();
    exp = exp_q.pop_front();
    AES_START = 1'b0;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL short_first got %h exp %h", got, exp);
    end
`ifdef AES_SEQ_ABORT_EN
    @(negedge CLK);
    got = obs();
    checks++;
    if (got !== 15'd0) begin
      errors++;
      $display("FAIL short_abort got %h exp %h", got, 15'd0);
    end
`else
    for (int i = 1; i < n; i++) begin
      @(negedge CLK);
      got = obs();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL short_trace cyc %0d got %h exp %h", i, got, exp);
      end
    end
    @(negedge CLK);
    got = obs();
    checks++;
    if (got !== 15'd0) begin
      errors++;
      $display("FAIL short_done_once got %h exp %h", got, 15'd0);
    end
`endif
    $display("run short: start pulse of 1 cycle handled");
  endtask

  task automatic test_reset_mid_run();
    logic [14:0] got, exp;
    int seen;
    push_run_trace();
    AES_START = 1'b1;
    for (int i = 0; i <= IDX_RESET; i++) begin
      @(negedge CLK);
      got = obs();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rstmid_trace cyc %0d got %h exp %h", i, got, exp);
      end
    end
    RESET_N   = 1'b0;
    AES_START = 1'b0;
    @(negedge CLK);
    got = obs();
    checks++;
    if (got !== 15'd0) begin
      errors++;
      $display("FAIL rstmid_idle got %h exp %h", got, 15'd0);
    end
    RESET_N = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (RESULT_WE !== 1'b0 || AES_DONE !== 1'b0 || BUSY !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstmid_quiet got %0d active cycles exp 0", seen);
    end
    $display("run reset_mid: reset during round 5 IMC");
  endtask

  task automatic test_abort();
    logic [14:0] got, exp;
    int n, seen;
    push_run_trace();
    n = exp_q.size();
    AES_START = 1'b1;
    for (int i = 0; i <= IDX_ABORT; i++) begin
      @(negedge CLK);
      got = obs();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort_trace cyc %0d got %h exp %h", i, got, exp);
      end
    end
    AES_START = 1'b0;
`ifdef AES_SEQ_ABORT_EN
    @(negedge CLK);
    got = obs();
    checks++;
    if (got !== 15'd0) begin
      errors++;
      $display("FAIL abort_idle got %h exp %h", got, 15'd0);
    end
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (RESULT_WE !== 1'b0 || AES_DONE !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles exp 0", seen);
    end
`else
    seen = 0;
    for (int i = IDX_ABORT + 1; i < n; i++) begin
      @(negedge CLK);
      got = obs();
      exp = exp_q.pop_front();
      if (AES_DONE === 1'b1) seen = i;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort_ignored cyc %0d got %h exp %h", i, got, exp);
      end
    end
    checks++;
    if (seen != LAT) begin
      errors++;
      $display("FAIL abort_latency got %0d exp %0d", seen, LAT);
    end
    @(negedge CLK);
    got = obs();
    checks++;
    if (got !== 15'd0) begin
      errors++;
      $display("FAIL abort_done_exit got %h exp %h", got, 15'd0);
    end
`endif
    $display("run abort: start dropped during round 3 ISB");
  endtask

  initial begin
    RESET_N   = 1'b0;
    AES_START = 1'b0;
    test_reset();
    test_full_run("first");
    test_back_to_back();
    @(negedge CLK);
    test_short_pulse();
    @(negedge CLK);
    test_reset_mid_run();
    @(negedge CLK);
    test_abort();
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
